// File: rtl/census_pkg.sv
// Shared opcodes, FSM state encoding and window-size derivations for the census cost engine.
package census_pkg;

  localparam logic [3:0] OP_PAD      = 4'h1;
  localparam logic [3:0] OP_PUSH     = 4'h2;
  localparam logic [3:0] OP_SET_CNT  = 4'h3;
  localparam logic [3:0] OP_SET_ACC  = 4'h4;
  localparam logic [3:0] OP_WTA_CLR  = 4'h6;
  localparam logic [3:0] OP_GET_CNT  = 4'h7;
  localparam logic [3:0] OP_LOAD_REF = 4'h8;
  localparam logic [3:0] OP_GET_WORD = 4'h9;
  localparam logic [3:0] OP_HAM      = 4'hD;
  localparam logic [3:0] OP_HAM_ACC  = 4'hE;
  localparam logic [3:0] OP_WTA      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  function automatic int calcNpix(input int winW, input int winH);
    return winW * winH;
  endfunction

  function automatic int calcNb(input int winW, input int winH);
    return winW * winH - 1;
  endfunction

  function automatic int calcNw(input int nb);
    return (nb + 31) / 32;
  endfunction

  function automatic int calcHw(input int nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/census_cost_engine_if.sv
// Command/result bus of the census cost engine: start strobe, opcode and operand in, result and done out.
interface census_cost_engine_if;
  logic        iStart;
  logic [3:0]  iOp;
  logic [31:0] iA;
  logic [31:0] oRes;
  logic        oDone;

  modport master (output iStart, iOp, iA, input oRes, oDone);
  modport slave  (input iStart, iOp, iA, output oRes, oDone);
endinterface

// File: rtl/census_popcount.sv
// Two-stage registered popcount: stage 0 captures the vector, stage 1 holds 16-bit group sums;
// the final group adder is combinational so the caller can register the total in its own result flop.
module census_popcount #(
  parameter int NB = 120,
  parameter int HW = $clog2(NB + 1)
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iEn,
  input  logic          iVld,
  input  logic [NB-1:0] iVec,
  output logic          oVld,
  output logic [HW-1:0] oCount
);

  localparam int GRP = 16;
  localparam int NG  = (NB + GRP - 1) / GRP;
  localparam int GW  = $clog2(GRP + 1);

  logic [NB-1:0]     vec_p0;
  logic              vld_p0;
  logic [GW-1:0]     part_p1 [NG];
  logic              vld_p1;
  logic [NG*GRP-1:0] vecPad;
  logic [GW-1:0]     partSum [NG];

  always_comb begin
    vecPad = '0;
    vecPad[NB-1:0] = vec_p0;
    for (int g = 0; g < NG; g++) begin
      partSum[g] = '0;
      for (int b = 0; b < GRP; b++)
        partSum[g] = partSum[g] + GW'(vecPad[g*GRP + b]);
    end
  end

  always_comb begin
    oCount = '0;
    for (int g = 0; g < NG; g++)
      oCount = oCount + HW'(part_p1[g]);
  end

  // stage 0: capture vector
  always_ff @(posedge iClk) begin
    if (iReset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (iEn) begin
      vld_p0 <= iVld;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iEn) begin
      vec_p0  <= iVec;
      // stage 1: group partial sums
      part_p1 <= partSum;
    end
  end

  assign oVld = vld_p1;

endmodule

// File: rtl/census_cost_engine.sv
// Census-transform / Hamming-cost custom instruction with start/done handshake.
// Define CENSUS_WTA_EN to build the winner-take-all registers and the WTA_CLR / WTA opcodes.
module census_cost_engine
  import census_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int WIN_W   = 11,
  parameter int WIN_H   = 11,
  parameter int PAD_MAX = 6
) (
  input logic                 iClk,
  input logic                 iReset,
  input logic                 iClk_en,
  census_cost_engine_if.slave bus
);

  localparam int NPIX = calcNpix(WIN_W, WIN_H);
  localparam int NB   = calcNb(WIN_W, WIN_H);
  localparam int C    = (NPIX - 1) / 2;
  localparam int NW   = calcNw(NB);
  localparam int HW   = calcHw(NB);
  localparam logic [PIX_W-1:0] FILL_PIX = '1;

  logic [PIX_W-1:0] pix [NPIX];
  logic [PIX_W-1:0] rCmp;
  logic [NB-1:0]    refCode;
  logic [NB-1:0]    liveCode;
  logic [NW*32-1:0] codeWide;
  logic [31:0]      codeWord;
  logic [31:0]      acc, accNext;
  logic [31:0]      cnt, cntNext;
  logic [31:0]      resQ, resNext;
  logic [3:0]       opQ, opNext;
  logic [2:0]       padLeft, padNext, padN;
  state_t           state, stateNext;
  logic             shiftEn, cmpLoad, refLoad, popStart, popVld;
  logic [PIX_W-1:0] shiftVal;
  logic [HW-1:0]    popCount;

`ifdef CENSUS_WTA_EN
  logic [HW-1:0] best, bestNext;
  logic [15:0]   idx, idxNext, bidx, bidxNext;
`endif

  // Centre pixel C is skipped, so bits at and above C come from the next pixel along.
  always_comb begin
    for (int j = 0; j < NB; j++)
      liveCode[j] = (pix[(j < C) ? j : j + 1] < rCmp);
    codeWide = '0;
    codeWide[NB-1:0] = liveCode;
    codeWord = '0;
    for (int w = 0; w < NW; w++)
      if (bus.iA[7:0] == 8'(w)) codeWord = codeWide[w*32 +: 32];
  end

  always_comb begin
    padN = (int'(bus.iA[2:0]) > PAD_MAX) ? 3'(PAD_MAX) : bus.iA[2:0];
  end

  census_popcount #(.NB(NB), .HW(HW)) uPop (
    .iClk   (iClk),
    .iReset (iReset),
    .iEn    (iClk_en),
    .iVld   (popStart),
    .iVec   (liveCode ^ refCode),
    .oVld   (popVld),
    .oCount (popCount)
  );

  always_comb begin
    stateNext = state;
    resNext   = resQ;
    opNext    = opQ;
    padNext   = padLeft;
    accNext   = acc;
    cntNext   = cnt;
    shiftEn   = 1'b0;
    shiftVal  = FILL_PIX;
    cmpLoad   = 1'b0;
    refLoad   = 1'b0;
    popStart  = 1'b0;
`ifdef CENSUS_WTA_EN
    bestNext  = best;
    idxNext   = idx;
    bidxNext  = bidx;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.iStart) begin
          opNext    = bus.iOp;
          cntNext   = cnt + 32'd1;
          resNext   = '0;
          stateNext = ST_DONE;
          case (bus.iOp)
            OP_PAD: begin
              if (padN != 3'd0) begin
                shiftEn = 1'b1;
                if (padN != 3'd1) begin
                  padNext   = padN - 3'd1;
                  stateNext = ST_EXEC;
                end
              end
            end
            OP_PUSH: begin
              shiftEn  = 1'b1;
              shiftVal = bus.iA[PIX_W-1:0];
            end
            OP_SET_CNT:  cntNext = bus.iA;
            OP_SET_ACC:  accNext = bus.iA;
            OP_GET_CNT:  resNext = cnt + 32'd1;
            OP_LOAD_REF: begin
              cmpLoad   = 1'b1;
              stateNext = ST_EXEC;
            end
            OP_GET_WORD: resNext = codeWord;
            OP_HAM, OP_HAM_ACC: begin
              popStart  = 1'b1;
              stateNext = ST_EXEC;
            end
`ifdef CENSUS_WTA_EN
            OP_WTA_CLR: begin
              bestNext = '1;
              idxNext  = '0;
              bidxNext = '0;
            end
            OP_WTA: begin
              popStart  = 1'b1;
              stateNext = ST_EXEC;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        case (opQ)
          OP_PAD: begin
            shiftEn = 1'b1;
            if (padLeft == 3'd1) stateNext = ST_DONE;
            else                 padNext   = padLeft - 3'd1;
          end
          // rCmp was loaded on the start edge, so the live code already reflects it here.
          OP_LOAD_REF: begin
            refLoad   = 1'b1;
            resNext   = codeWide[31:0];
            stateNext = ST_DONE;
          end
          default: begin
            if (popVld) begin
              stateNext = ST_DONE;
              if (opQ == OP_HAM_ACC) begin
                accNext = acc + 32'(popCount);
                resNext = acc + 32'(popCount);
              end else begin
                resNext = 32'(popCount);
              end
`ifdef CENSUS_WTA_EN
              if (opQ == OP_WTA) begin
                if (popCount < best) begin
                  bestNext = popCount;
                  bidxNext = idx;
                end
                idxNext = idx + 16'd1;
                resNext = {bidxNext, 16'(bestNext)};
              end
`endif
            end
          end
        endcase
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state   <= ST_IDLE;
      opQ     <= '0;
      padLeft <= '0;
      cnt     <= '0;
      acc     <= '0;
      resQ    <= '0;
      rCmp    <= '0;
      refCode <= '0;
      for (int k = 0; k < NPIX; k++) pix[k] <= FILL_PIX;
`ifdef CENSUS_WTA_EN
      best    <= '1;
      idx     <= '0;
      bidx    <= '0;
`endif
    end else if (iClk_en) begin
      state   <= stateNext;
      opQ     <= opNext;
      padLeft <= padNext;
      cnt     <= cntNext;
      acc     <= accNext;
      resQ    <= resNext;
      if (cmpLoad) rCmp <= bus.iA[PIX_W-1:0];
      if (refLoad) refCode <= liveCode;
      if (shiftEn) begin
        pix[0] <= shiftVal;
        for (int k = 1; k < NPIX; k++) pix[k] <= pix[k-1];
      end
`ifdef CENSUS_WTA_EN
      best    <= bestNext;
      idx     <= idxNext;
      bidx    <= bidxNext;
`endif
    end
  end

  assign bus.oRes  = resQ;
  assign bus.oDone = (state == ST_DONE);

endmodule

// File: tb/tb_census_cost_engine.sv
// Scoreboard bench for census_cost_engine at the default 11x11, 8-bit configuration.
module tb_census_cost_engine;
  import census_pkg::*;

  logic iClk = 1'b0;
  logic iReset;
  logic iClk_en;

  census_cost_engine_if bus();

  census_cost_engine dut (
    .iClk    (iClk),
    .iReset  (iReset),
    .iClk_en (iClk_en),
    .bus     (bus)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          startCyc;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin : monitor
    exp_t e;
    if (bus.oDone === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("FAIL unexpected_done: oDone=1 oRes=%h with no command pending", bus.oRes);
      end else begin
        e = expQ.pop_front();
        if (bus.oRes !== e.res) begin
          nFails++;
          $display("FAIL %s result: got %h expected %h", e.name, bus.oRes, e.res);
        end
        nChecks++;
        if (cyc - e.startCyc != e.lat) begin
          nFails++;
          $display("FAIL %s latency: got %0d expected %0d", e.name, cyc - e.startCyc, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] res,
                       input int lat, input string name);
    exp_t e;
    @(negedge iClk);
    bus.iStart = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    e.res = res; e.lat = lat; e.startCyc = cyc; e.name = name;
    expQ.push_back(e);
    @(negedge iClk);
    bus.iStart = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge iClk);
      n++;
    end
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL %s timeout: %0d results pending after %0d cycles", name, expQ.size(), n);
      expQ.delete();
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] res,
                      input int lat, input string name);
    issue(op, a, res, lat, name);
    waitDone(name);
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (3) @(negedge iClk);
    nChecks++;
    if (bus.oDone !== 1'b0) begin
      nFails++;
      $display("FAIL reset_done: got %b expected 0", bus.oDone);
    end
    nChecks++;
    if (bus.oRes !== 32'h0) begin
      nFails++;
      $display("FAIL reset_res: got %h expected 00000000", bus.oRes);
    end
    iReset = 1'b0;
  endtask

  // Fresh matrix is all 0xFF, so nothing is below 0x80 and every code bit is 0.
  task automatic test_blank();
    send(OP_LOAD_REF, 32'h80, 32'h0, 2, "loadref_blank");
    for (int w = 0; w < 4; w++) send(OP_GET_WORD, w, 32'h0, 1, "getword_blank");
    send(OP_HAM, 0, 32'h0, 3, "ham_blank");
    send(OP_GET_WORD, 4, 32'h0, 1, "getword_oob");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 121; i++) send(OP_PUSH, 32'h10, 32'h0, 1, "push_low");
    send(OP_LOAD_REF, 32'h80, 32'hFFFF_FFFF, 2, "loadref_full");
    send(OP_GET_WORD, 1, 32'hFFFF_FFFF, 1, "getword1_full");
    send(OP_GET_WORD, 3, 32'h00FF_FFFF, 1, "getword3_full");
  endtask

  task automatic test_ham();
    for (int i = 0; i < 5; i++) send(OP_PUSH, 32'hFF, 32'h0, 1, "push_high");
    send(OP_HAM, 0, 32'd5, 3, "ham5");
  endtask

  task automatic test_acc();
    send(OP_SET_ACC, 32'd100, 32'h0, 1, "setacc100");
    send(OP_HAM_ACC, 0, 32'd105, 3, "hamacc105");
    send(OP_HAM_ACC, 0, 32'd110, 3, "hamacc110");
    send(OP_SET_ACC, 32'hFFFF_FFFE, 32'h0, 1, "setacc_wrap");
    send(OP_HAM_ACC, 0, 32'd3, 3, "hamacc_wrap");
  endtask

  // Filler pixels are all-ones, so each one clears one more low code bit.
  task automatic test_pad();
    send(OP_PAD, 32'd3, 32'h0, 3, "pad3");
    send(OP_HAM, 0, 32'd8, 3, "ham_pad3");
    send(OP_PAD, 32'd0, 32'h0, 1, "pad0");
    send(OP_GET_WORD, 0, 32'hFFFF_FF00, 1, "getword_pad0");
    send(OP_PAD, 32'd7, 32'h0, 6, "pad7");
    send(OP_GET_WORD, 0, 32'hFFFF_C000, 1, "getword_pad7");
  endtask

  task automatic test_clk_en();
    issue(OP_HAM, 0, 32'd14, 7, "ham_clken");
    iClk_en = 1'b0;
    repeat (4) begin
      @(negedge iClk);
      nChecks++;
      if (bus.oDone !== 1'b0) begin
        nFails++;
        $display("FAIL clken_frozen_done: got %b expected 0", bus.oDone);
      end
    end
    iClk_en = 1'b1;
    waitDone("ham_clken");
  endtask

  task automatic test_cnt();
    send(OP_SET_CNT, 32'd10, 32'h0, 1, "setcnt10");
    send(OP_GET_CNT, 0, 32'd11, 1, "getcnt11");
    send(4'h0, 32'h1234, 32'h0, 1, "unknown_op");
    send(OP_GET_CNT, 0, 32'd13, 1, "getcnt13");
    send(OP_SET_CNT, 32'hFFFF_FFFF, 32'h0, 1, "setcnt_max");
    send(OP_GET_CNT, 0, 32'h0, 1, "getcnt_wrap");
  endtask

  task automatic test_reset_abort();
    @(negedge iClk);
    bus.iStart = 1'b1;
    bus.iOp    = OP_HAM;
    bus.iA     = 32'h0;
    @(negedge iClk);
    bus.iStart = 1'b0;
    iReset     = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    repeat (5) begin
      @(negedge iClk);
      nChecks++;
      if (bus.oDone !== 1'b0) begin
        nFails++;
        $display("FAIL abort_done: got %b expected 0", bus.oDone);
      end
    end
    nChecks++;
    if (bus.oRes !== 32'h0) begin
      nFails++;
      $display("FAIL abort_res: got %h expected 00000000", bus.oRes);
    end
    send(OP_GET_CNT, 0, 32'd1, 1, "getcnt_after_abort");
  endtask

`ifdef CENSUS_WTA_EN
  // Costs 9, 4, 4, 7 against refs built from the pushes below.
  task automatic test_wta();
    send(OP_LOAD_REF, 32'h80, 32'h0, 2, "wta_ref0");
    send(OP_WTA_CLR, 0, 32'h0, 1, "wta_clr");
    for (int i = 0; i < 9; i++) send(OP_PUSH, 32'h10, 32'h0, 1, "wta_push_low");
    send(OP_WTA, 0, 32'h0000_0009, 3, "wta_c9");
    send(OP_LOAD_REF, 32'h80, 32'h0000_01FF, 2, "wta_ref1ff");
    for (int i = 0; i < 2; i++) send(OP_PUSH, 32'hFF, 32'h0, 1, "wta_push_high");
    send(OP_WTA, 0, 32'h0001_0004, 3, "wta_c4a");
    send(OP_WTA, 0, 32'h0001_0004, 3, "wta_c4b");
    send(OP_PUSH, 32'hFF, 32'h0, 1, "wta_push_high");
    send(OP_PUSH, 32'h10, 32'h0, 1, "wta_push_low");
    send(OP_WTA, 0, 32'h0001_0004, 3, "wta_c7");
  endtask
`else
  task automatic test_wta();
    send(OP_WTA, 32'h55, 32'h0, 1, "wta_absent");
    send(OP_WTA_CLR, 32'h55, 32'h0, 1, "wtaclr_absent");
    send(OP_GET_CNT, 0, 32'd4, 1, "getcnt_wta_absent");
  endtask
`endif

  initial begin
    bus.iStart = 1'b0;
    bus.iOp    = 4'h0;
    bus.iA     = 32'h0;
    iReset     = 1'b1;
    iClk_en    = 1'b1;
    test_reset();
    test_blank();
    test_fill();
    test_ham();
    test_acc();
    test_pad();
    test_clk_en();
    test_cnt();
    test_reset_abort();
    test_wta();
    repeat (3) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", nChecks);
    $fatal(1, "watchdog");
  end

endmodule
